adc_spi_model_n: RTL and testbench
==================================

ADC_SPI_MODEL_N -- requirements
Module: adc_spi_model_n

Interface
REQ-001 Parameter NUM_CH, default 8, number of modelled channels (1..8).
REQ-002 Parameter RES_BITS, default 12, converter resolution (8..12).
REQ-003 Parameter PAIRED_MODE, default 0; 0 = pipelined (every frame returns previous frame's channel), 1 = legacy two-frame pairs.
REQ-004 Parameter CH_EN_MASK, default 8'hFF, per-channel valid mask, bit i = channel i.
REQ-005 Parameter DROOP_STEP, default 0, LSBs subtracted from accumulated droop per completed data frame.
REQ-006 clk  input  1  system clock; one clock, all state on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SS_n  input  1  active-low slave select (asynchronous to clk).
REQ-009 SCLK  input  1  SPI serial clock (asynchronous to clk).
REQ-010 MOSI  input  1  serial command in.
REQ-011 ana_in  input  NUM_CH*12  channel values, channel i at [12i+11:12i].
REQ-012 MISO  output  1  serial data out.
REQ-013 rdy  output  1  one-clk pulse per completed 16-bit frame.
REQ-014 last_ch  output  3  channel field of last completed frame.
REQ-015 bad_ch  output  1  sticky invalid-channel flag.
REQ-016 frame_abort  output  1  one-clk pulse on frame terminated with fewer than 16 bits.

Function
REQ-017 SS_n, SCLK, MOSI double-flop synchronised; SCLK edges detected from 3rd stage; SS_n falling/rising edges detected likewise.
REQ-018 Frame: SS_n low, 16 SCLK cycles, mode 3; MOSI sampled on SCLK rise, MISO updated on SCLK fall, MSB first.
REQ-019 Command channel field = rx bits [13:11]; other bits ignored.
REQ-020 On synced SS_n fall: tx shift register loaded with response word; 5-bit bit counter cleared.
REQ-021 MISO = tx[15] while SS_n low; 0 while SS_n high.
REQ-022 On synced SS_n rise with bit count 16: rdy pulses next clk, last_ch updated; with count 1..15: frame_abort pulses, no other state changes; count >16 treated as 16, only first 16 bits kept.
REQ-023 Response word = {4'b0000, sample[RES_BITS-1:0], (12-RES_BITS) zeros}; sample = ana_in channel value >> (12-RES_BITS), minus droop, saturating at 0.
REQ-024 Channel valid iff index < NUM_CH and CH_EN_MASK bit set; invalid channel selects sample 0 and sets bad_ch.
REQ-025 Pipelined mode: each completed frame latches its channel field; response word for next frame computed from that channel, captured at rdy.
REQ-026 Paired mode: state FIRST -> (frame done) latch channel, go SECOND; SECOND -> (frame done) return latched channel data, go FIRST; response in FIRST-phase frames is 16'h0000.
REQ-027 Droop: 12-bit accumulator, += DROOP_STEP after every frame that returned channel data (pipelined: every frame after the first; paired: SECOND frames), saturating at 12'hFFF.
REQ-028 ana_in sampled at the rdy clk of the selecting frame; later changes do not affect that response.
REQ-029 SS_n fall while rdy pending: rdy still issued, new frame loads updated response.

Reset
REQ-030 rst_n low: MISO 0, rdy 0, frame_abort 0, last_ch 0, bad_ch 0, droop 0, state FIRST, latched channel 0, response word 16'h0000, counters 0.
REQ-031 Reset mid-frame discards the frame; no rdy or frame_abort generated after release until a new SS_n fall.

Verification
REQ-032 Defaults, ana_in ch0=12'hC00, ch5=12'h3A5; frames cmd ch5 then ch0 -> second frame MISO word 16'h03A5, rdy twice, last_ch 0.
REQ-033 PAIRED_MODE=1, DROOP_STEP=16, ch0=12'hC00; four frames selecting ch0 -> data frames return 16'h0C00 then 16'h0BF0; FIRST frames return 16'h0000.
REQ-034 NUM_CH=6; frame cmd ch7 then any -> response 16'h0000, bad_ch 1 until reset.
REQ-035 RES_BITS=8, ch4=12'hABC; select ch4 then read -> 16'h0AB0.
REQ-036 SS_n raised after 9 SCLKs -> frame_abort one clk, no rdy, last_ch unchanged; next full frame normal.
REQ-037 rst_n asserted at bit 8 of a frame -> all outputs at REQ-030 values, no rdy after release.

Source files
------------

// File: rtl/adc_spi_model_n_if.sv
// SPI bus between a master and the ADC model.
// The master drives slave select, serial clock and command data; the slave returns MISO.
interface adc_spi_model_n_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc_spi_model_n.sv
// Behavioural SPI ADC slave in mode 3 with 16-bit frames.
// Supports pipelined or paired-frame readout, a per-channel enable mask and cumulative droop.
module adc_spi_model_n #(
  parameter int          NUM_CH      = 8,
  parameter int          RES_BITS    = 12,
  parameter int          PAIRED_MODE = 0,
  parameter logic [7:0]  CH_EN_MASK  = 8'hFF,
  parameter int          DROOP_STEP  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adc_spi_model_n_if.slave       spi,
  input  logic [NUM_CH*12-1:0]   ana_in,
  output logic                   rdy,
  output logic [2:0]             last_ch,
  output logic                   bad_ch,
  output logic                   frame_abort
);

  localparam int SHIFT = 12 - RES_BITS;

  typedef enum logic {ST_FIRST, ST_SECOND} state_t;

  logic [2:0]  r_ss_s, r_sclk_s;
  logic [1:0]  r_mosi_s;
  logic        r_in_frame;
  logic [4:0]  r_bitcnt;
  logic [13:0] r_rx;
  logic [15:0] r_tx;
  logic        r_rdy, r_abort;
  logic [2:0]  r_last_ch;
  logic        r_bad;
  logic [11:0] r_droop;
  logic [15:0] r_resp;
  state_t      r_state;

  logic        w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  logic [7:0][11:0] w_ana_arr;
  logic [11:0] w_raw, w_smp, w_diff;
  logic [12:0] w_droop_sum;
  logic        w_ch_valid;
  state_t      w_state_next;
  logic [11:0] w_droop_next;
  logic [15:0] w_resp_next;
  logic        w_bad_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_s   <= '0;
      r_sclk_s <= '1;
      r_mosi_s <= '0;
    end else begin
      r_ss_s   <= {r_ss_s[1:0], spi.SS_n};
      r_sclk_s <= {r_sclk_s[1:0], spi.SCLK};
      r_mosi_s <= {r_mosi_s[0], spi.MOSI};
    end
  end

  assign w_ss_fall   =  r_ss_s[2]   & ~r_ss_s[1];
  assign w_ss_rise   = ~r_ss_s[2]   &  r_ss_s[1];
  assign w_sclk_rise = ~r_sclk_s[2] &  r_sclk_s[1];
  assign w_sclk_fall =  r_sclk_s[2] & ~r_sclk_s[1];

  // The leading SCLK fall of mode 3 presents the MSB already loaded, so shifting starts after bit 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_frame <= 1'b0;
      r_bitcnt   <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_rdy      <= 1'b0;
      r_abort    <= 1'b0;
      r_last_ch  <= '0;
    end else begin
      r_rdy   <= 1'b0;
      r_abort <= 1'b0;
      if (w_ss_fall) begin
        r_in_frame <= 1'b1;
        r_bitcnt   <= '0;
        r_rx       <= '0;
        r_tx       <= r_rdy ? w_resp_next : r_resp;
      end else if (w_ss_rise && r_in_frame) begin
        r_in_frame <= 1'b0;
        if (r_bitcnt == 5'd16) begin
          r_rdy     <= 1'b1;
          r_last_ch <= r_rx[13:11];
        end else if (r_bitcnt != '0) begin
          r_abort <= 1'b1;
        end
      end else if (r_in_frame) begin
        if (w_sclk_rise && r_bitcnt != 5'd16) begin
          r_rx     <= {r_rx[12:0], r_mosi_s[1]};
          r_bitcnt <= r_bitcnt + 5'd1;
        end
        if (w_sclk_fall && r_bitcnt != '0 && r_bitcnt != 5'd16)
          r_tx <= {r_tx[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FIRST;
      r_droop <= '0;
      r_resp  <= '0;
      r_bad   <= 1'b0;
    end else if (r_rdy) begin
      r_state <= w_state_next;
      r_droop <= w_droop_next;
      r_resp  <= w_resp_next;
      r_bad   <= w_bad_next;
    end
  end

  assign w_ana_arr  = 96'(ana_in);
  assign w_raw      = w_ana_arr[r_last_ch];
  assign w_ch_valid = (32'(r_last_ch) < NUM_CH) && CH_EN_MASK[r_last_ch];

  // ST_SECOND in pipelined mode just means "a frame has already completed since reset".
  always_comb begin
    w_state_next = r_state;
    w_droop_next = r_droop;
    w_resp_next  = r_resp;
    w_bad_next   = r_bad;
    w_droop_sum  = {1'b0, r_droop} + 13'(DROOP_STEP);
    w_smp        = '0;
    w_diff       = '0;

    if (r_state == ST_SECOND)
      w_droop_next = w_droop_sum[12] ? 12'hFFF : w_droop_sum[11:0];

    if (PAIRED_MODE != 0 && r_state == ST_SECOND) begin
      w_state_next = ST_FIRST;
      w_resp_next  = '0;
    end else begin
      w_state_next = ST_SECOND;
      if (w_ch_valid)
        w_smp = w_raw >> SHIFT;
      else
        w_bad_next = 1'b1;
      w_diff      = (w_smp >= w_droop_next) ? (w_smp - w_droop_next) : '0;
      w_resp_next = {4'b0000, 12'(w_diff << SHIFT)};
    end
  end

  assign spi.MISO    = r_in_frame & r_tx[15];
  assign rdy         = r_rdy;
  assign frame_abort = r_abort;
  assign last_ch     = r_last_ch;
  assign bad_ch      = r_bad;

endmodule

// File: tb/tb_adc_spi_model_n.sv
// Drives one SPI stream into three differently configured ADC models and checks each
// against a frame-level reference model.
module tb_adc_spi_model_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ss_n, sclk, mosi;
  logic [95:0] ana;
  logic [2:0]  rdy, abort, bad, miso;
  logic [2:0]  lch [3];

  adc_spi_model_n_if spi0 ();
  adc_spi_model_n_if spi1 ();
  adc_spi_model_n_if spi2 ();

  assign spi0.SS_n = ss_n; assign spi0.SCLK = sclk; assign spi0.MOSI = mosi;
  assign spi1.SS_n = ss_n; assign spi1.SCLK = sclk; assign spi1.MOSI = mosi;
  assign spi2.SS_n = ss_n; assign spi2.SCLK = sclk; assign spi2.MOSI = mosi;
  assign miso = {spi2.MISO, spi1.MISO, spi0.MISO};

  adc_spi_model_n #(.NUM_CH(8), .RES_BITS(12), .PAIRED_MODE(0), .CH_EN_MASK(8'hFF), .DROOP_STEP(0)) u_pipe (
    .clk(clk), .rst_n(rst_n), .spi(spi0), .ana_in(ana),
    .rdy(rdy[0]), .last_ch(lch[0]), .bad_ch(bad[0]), .frame_abort(abort[0]));

  adc_spi_model_n #(.NUM_CH(8), .RES_BITS(12), .PAIRED_MODE(1), .CH_EN_MASK(8'hFF), .DROOP_STEP(16)) u_pair (
    .clk(clk), .rst_n(rst_n), .spi(spi1), .ana_in(ana),
    .rdy(rdy[1]), .last_ch(lch[1]), .bad_ch(bad[1]), .frame_abort(abort[1]));

  adc_spi_model_n #(.NUM_CH(6), .RES_BITS(8), .PAIRED_MODE(0), .CH_EN_MASK(8'hF7), .DROOP_STEP(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .spi(spi2), .ana_in(ana[71:0]),
    .rdy(rdy[2]), .last_ch(lch[2]), .bad_ch(bad[2]), .frame_abort(abort[2]));

  int         p_nch  [3] = '{8, 8, 6};
  int         p_res  [3] = '{12, 12, 8};
  bit         p_pair [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] p_mask [3] = '{8'hFF, 8'hFF, 8'hF7};
  int         p_step [3] = '{0, 16, 0};

  int          m_droop [3];
  bit          m_second[3];
  logic [15:0] m_resp  [3];
  bit          m_bad   [3];
  int          m_last  [3];
  int          m_nfr   [3];
  int          exp_rdy [3] = '{0, 0, 0};
  int          exp_ab  [3] = '{0, 0, 0};
  int          got_rdy [3] = '{0, 0, 0};
  int          got_ab  [3] = '{0, 0, 0};
  logic [15:0] last_w  [3];

  int n_vec = 0;
  int n_err = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy[k])   got_rdy[k]++;
      if (abort[k]) got_ab[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_droop[k] = 0; m_second[k] = 1'b0; m_resp[k] = '0;
      m_bad[k] = 1'b0; m_last[k] = 0; m_nfr[k] = 0;
    end
  endtask

  // One completed 16-bit frame selecting channel c, with ana as it stands at the frame end.
  task automatic model_frame(input int c);
    int s;
    bit data_frame;
    int scale;
    for (int k = 0; k < 3; k++) begin
      scale = 1 << (12 - p_res[k]);
      data_frame = p_pair[k] ? m_second[k] : (m_nfr[k] > 0);
      if (data_frame)
        m_droop[k] = (m_droop[k] + p_step[k] > 4095) ? 4095 : m_droop[k] + p_step[k];
      if (p_pair[k] && m_second[k]) begin
        m_second[k] = 1'b0;
        m_resp[k]   = '0;
      end else begin
        if (p_pair[k]) m_second[k] = 1'b1;
        if (c < p_nch[k] && p_mask[k][c]) begin
          s = int'(ana[12*c +: 12]) / scale;
        end else begin
          s = 0;
          m_bad[k] = 1'b1;
        end
        s = (s > m_droop[k]) ? s - m_droop[k] : 0;
        m_resp[k] = 16'(s * scale);
      end
      m_last[k] = c;
      m_nfr[k]++;
      exp_rdy[k]++;
    end
  endtask

  task automatic check_status();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_rdy_count", k),   got_rdy[k], exp_rdy[k]);
      chk($sformatf("d%0d_abort_count", k), got_ab[k],  exp_ab[k]);
      chk($sformatf("d%0d_last_ch", k),     32'(lch[k]), m_last[k]);
      chk($sformatf("d%0d_bad_ch", k),      32'(bad[k]), 32'(m_bad[k]));
    end
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
    check_status();
    for (int k = 0; k < 3; k++)
      chk($sformatf("d%0d_miso_idle", k), 32'(miso[k]), 0);
  endtask

  // Status of the previous frame is checked a few clocks into this one, so short SS_n gaps work.
  task automatic xfer(input logic [15:0] cmd, input int nbits, input int gap, input logic [95:0] new_ana);
    logic [15:0] w [3];
    for (int k = 0; k < 3; k++) w[k] = '0;
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
    check_status();
    ana = new_ana;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = (i < 16) ? cmd[15-i] : 1'($urandom);
      repeat (4) @(negedge clk);
      if (i < 16)
        for (int k = 0; k < 3; k++) w[k][15-i] = miso[k];
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    if (nbits >= 16) begin
      for (int k = 0; k < 3; k++) chk($sformatf("d%0d_miso_word", k), w[k], m_resp[k]);
      model_frame(int'(cmd[13:11]));
    end else if (nbits > 0) begin
      for (int k = 0; k < 3; k++) exp_ab[k]++;
    end
    for (int k = 0; k < 3; k++) last_w[k] = w[k];
    repeat (gap) @(negedge clk);
  endtask

  task automatic xfer_reset(input logic [15:0] cmd);
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
    check_status();
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; mosi = cmd[15-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_rst_miso", k),  32'(miso[k]),  0);
      chk($sformatf("d%0d_rst_rdy", k),   32'(rdy[k]),   0);
      chk($sformatf("d%0d_rst_abort", k), 32'(abort[k]), 0);
      chk($sformatf("d%0d_rst_last", k),  32'(lch[k]),   0);
      chk($sformatf("d%0d_rst_bad", k),   32'(bad[k]),   0);
    end
    ss_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (20) @(negedge clk);
    check_status();
  endtask

  function automatic logic [15:0] cmd_for(input int c);
    logic [15:0] r;
    r = 16'($urandom);
    r[13:11] = 3'(c);
    return r;
  endfunction

  initial begin
    logic [95:0] a;
    int nb;
    rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b1; mosi = 1'b0; ana = '0;
    model_reset();
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_init_miso", k),  32'(miso[k]),  0);
      chk($sformatf("d%0d_init_rdy", k),   32'(rdy[k]),   0);
      chk($sformatf("d%0d_init_abort", k), 32'(abort[k]), 0);
      chk($sformatf("d%0d_init_last", k),  32'(lch[k]),   0);
      chk($sformatf("d%0d_init_bad", k),   32'(bad[k]),   0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    a = {$urandom, $urandom, $urandom};
    a[11:0]  = 12'hC00;
    a[71:60] = 12'h3A5;
    xfer(cmd_for(0), 16, 4, a);
    chk("pair_first_frame0", last_w[1], 16'h0000);
    xfer(cmd_for(0), 16, 4, a);
    chk("pair_data_frame0", last_w[1], 16'h0C00);
    xfer(cmd_for(0), 16, 4, a);
    chk("pair_first_frame1", last_w[1], 16'h0000);
    xfer(cmd_for(0), 16, 4, a);
    chk("pair_data_frame1", last_w[1], 16'h0BF0);
    xfer(cmd_for(5), 16, 4, a);
    xfer(cmd_for(0), 16, 4, a);
    chk("pipe_ch5_word", last_w[0], 16'h03A5);
    settle();
    chk("pipe_last_ch0", 32'(lch[0]), 0);

    a[59:48] = 12'hABC;
    xfer(cmd_for(4), 16, 4, a);
    xfer(cmd_for(1), 16, 4, a);
    chk("alt_res8_word", last_w[2], 16'h0AB0);

    xfer(cmd_for(7), 16, 4, a);
    xfer(cmd_for(2), 16, 4, a);
    chk("alt_invalid_word", last_w[2], 16'h0000);
    settle();
    chk("alt_bad_sticky", 32'(bad[2]), 1);

    xfer(cmd_for(3), 9, 4, a);
    settle();
    xfer(cmd_for(6), 16, 1, a);
    xfer(cmd_for(1), 16, 1, {$urandom, $urandom, $urandom});

    xfer_reset(cmd_for(5));
    xfer(cmd_for(3), 16, 3, {$urandom, $urandom, $urandom});
    for (int k = 0; k < 3; k++) chk($sformatf("d%0d_post_reset_word", k), last_w[k], 16'h0000);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       nb = $urandom_range(1, 15);
        1:       nb = 17;
        default: nb = 16;
      endcase
      xfer(16'($urandom), nb, $urandom_range(1, 6), {$urandom, $urandom, $urandom});
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
